// File: rtl/sort_drain.sv
// Drains a toggle-handshake sorter head-first onto a valid/ready stream and keeps count/min/max stats.
// Latency: one element per GUARD+3 clocks with out_ready high; out_valid holds data until accepted.
// Optional order checker built when SORT_DRAIN_CHECK_EN is defined.
module sort_drain #(
    parameter int GUARD = 10,
    parameter int DW    = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             start,
    input  logic [DW-1:0]    tx_data,
    input  logic             empty,
    input  logic             idle,
    output logic             pop,
    output logic [DW-1:0]    out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic [DW-1:0]    min_val,
    output logic [DW-1:0]    max_val,
    output logic             order_err,
    output logic [2:0]       cst,
    output logic [2:0]       nst
);

    localparam int GW = (GUARD > 2) ? $clog2(GUARD) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_WAIT  = 3'b001,
        ST_OUT   = 3'b011,
        ST_POP   = 3'b010,
        ST_GUARD = 3'b110,
        ST_END   = 3'b111
    } state_t;

    state_t        cst_q;
    state_t        nst_c;
    logic          start_q;
    logic [GW-1:0] gcnt;
    logic          start_evt;
    logic          accept;

    assign start_evt = start ^ start_q;
    assign accept    = (cst_q == ST_OUT) && out_valid && out_ready;
    assign cst       = cst_q;
    assign nst       = nst_c;

    always_comb begin
        nst_c = cst_q;
        if (!enable) begin
            nst_c = ST_IDLE;
        end else begin
            case (cst_q)
                ST_IDLE:  if (start_evt) nst_c = ST_WAIT;
                ST_WAIT:  if (idle) nst_c = empty ? ST_END : ST_OUT;
                ST_OUT:   if (out_ready) nst_c = ST_POP;
                ST_POP:   nst_c = ST_GUARD;
                ST_GUARD: if (gcnt == GW'(GUARD - 1)) nst_c = ST_WAIT;
                ST_END:   nst_c = ST_IDLE;
                default:  nst_c = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cst_q     <= ST_IDLE;
            start_q   <= 1'b0;
            gcnt      <= '0;
            pop       <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            min_val   <= '0;
            max_val   <= '0;
        end else begin
            start_q   <= start;
            cst_q     <= nst_c;
            out_valid <= (nst_c == ST_OUT);
            done      <= (nst_c == ST_END);
            // pop only moves in ST_POP, so dropping enable never emits a stray toggle
            if (enable) begin
                case (cst_q)
                    ST_IDLE: if (start_evt) begin
                        count   <= '0;
                        min_val <= '0;
                        max_val <= '0;
                    end
                    ST_WAIT: if (idle && !empty) out_data <= tx_data;
                    ST_OUT: if (accept) begin
                        if (count != '1) count <= count + 1'b1;
                        if (count == '0) begin
                            min_val <= out_data;
                            max_val <= out_data;
                        end else begin
                            if (out_data < min_val) min_val <= out_data;
                            if (out_data > max_val) max_val <= out_data;
                        end
                    end
                    ST_POP: begin
                        pop  <= ~pop;
                        gcnt <= '0;
                    end
                    ST_GUARD: gcnt <= gcnt + 1'b1;
                    default: ;
                endcase
            end
        end
    end

`ifdef SORT_DRAIN_CHECK_EN
    logic [DW-1:0] prev_val;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_val  <= '0;
            order_err <= 1'b0;
        end else if (enable) begin
            if (cst_q == ST_IDLE && start_evt) begin
                order_err <= 1'b0;
            end else if (accept) begin
                prev_val <= out_data;
                // count==0 marks the first element of this drain
                if (count != '0 && out_data < prev_val) order_err <= 1'b1;
            end
        end
    end
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: doc/sort_drain.md
# sort_drain

Downstream drain stage for the `quicksort` sorter. It starts on a toggle request, reads the sorted contents head-first, and issues a toggle-style `pop` to the sorter for each element. Each element is presented on a valid/ready output stream while the block keeps count/min/max statistics. It sits between the sorter's `tx_data/pop/empty/idle` side and whatever consumes the sorted sequence.

## Interface
- `GUARD`, 10: wait cycles after each `pop` toggle before `idle`/`empty` are trusted again (≥2).
- `DW`, 16: data width, matches sorter `tx_data`.
- `CNT_W`, 8: element counter width.
- `clk` in 1: single clock, all logic on rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `enable` in 1: low forces state to `ST_IDLE`. Outputs hold, except `out_valid`, which goes to 0.
- `start` in 1: toggle request. Any change versus its registered copy is a start event.
- `tx_data` in DW: sorter head element.
- `empty` in 1: sorter holds no elements.
- `idle` in 1: sorter FSM idle. `tx_data` and `empty` are valid only when this is high.
- `pop` out 1: toggle to sorter. One toggle per element consumed.
- `out_data` out DW: current element.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: consumer accepts.
- `done` out 1: one-cycle pulse when the drain completes.
- `count` out CNT_W: elements drained since last start. Saturates at all-ones.
- `min_val`, `max_val` out DW: first and running extreme values.
- `order_err` out 1: sticky, sequence not non-decreasing. Only active with the macro.
- `cst`, `nst` out 3: current/next state, debug.

## Operation
- States are Gray-coded (`X^(X>>1)`): `ST_IDLE`=G(0), `ST_WAIT`=G(1), `ST_OUT`=G(2), `ST_POP`=G(3), `ST_GUARD`=G(4), `ST_END`=G(5).
- `ST_IDLE`
  - On a start event: clear `count`/`min_val`/`max_val`/`order_err`, then go to `ST_WAIT`.
  - Start events in any other state are ignored. The start copy register still updates.
- `ST_WAIT`
  - `idle && empty` → `ST_END`.
  - `idle && !empty` → `ST_OUT`; capture `tx_data` into `out_data` on this edge.
  - Otherwise stay.
- `ST_OUT`
  - `out_valid`=1.
  - On `out_valid && out_ready`: update stats and go to `ST_POP`.
  - Stats update: `count`+1, saturating. First element loads both `min_val` and `max_val`; later elements update by unsigned compare.
- `ST_POP`: invert `pop` for exactly one edge, then go to `ST_GUARD` with the guard counter = 0.
- `ST_GUARD`: count to `GUARD-1`, then go to `ST_WAIT`.
- `ST_END`: `done`=1 for one cycle, then `ST_IDLE`. Stats hold until the next start.
- Zero elements: WAIT → END. `count`=0; `min_val`/`max_val` stay 0.
- Reset mid-drain
  - All registers return to reset values; `pop` returns to 0.
  - The sorter shares `rstn`, so the toggle phases stay aligned.
  - An element shown but not yet accepted is lost.
- `enable` low mid-drain: state goes to `ST_IDLE`. `pop` holds its level, so no spurious toggle is issued.

## Timing
- Reset values: every output is 0; `cst`/`nst` = `ST_IDLE`.
- Start accept: toggle seen at edge N → `cst`=`ST_WAIT` after edge N.
- Element cycle with `out_ready` held high is `GUARD+3` clocks: WAIT 1, OUT 1, POP 1, GUARD `GUARD`.
- `out_data` is stable for the whole time `out_valid` is high.
- `out_valid` stays high until accepted; it never drops without a transfer, except on reset or `enable` low.
- `pop` toggles exactly once per accepted element, on the edge that leaves `ST_POP`.
- `done` is asserted in the cycle `cst`=`ST_END`. `count`/`min_val`/`max_val` are final in that cycle.
- `count` saturates at 2^CNT_W−1. It does not wrap.

## Configuration
- Macro: `SORT_DRAIN_CHECK_EN`.
- Defined:
  - For each element after the first, `tx_data` < previous accepted value sets `order_err` on the acceptance edge.
  - `order_err` stays set until the next start or reset.
- Undefined: `order_err` is tied to 0, and the previous-value register is not built.

## Test plan
- Push 5, 3, 9, 3, toggle sort, wait `idle`, toggle `start`, `out_ready`=1:
  - `out_data` sequence is 3, 3, 5, 9.
  - Exactly 4 `pop` toggles; `count`=4, `min_val`=3, `max_val`=9.
  - One `done` pulse; `order_err`=0.
- Empty sorter, toggle `start`: `done` within 3 clocks; `count`=0; zero `pop` toggles.
- Back-pressure: hold `out_ready`=0 for 50 clocks on element 2. `out_valid` stays 1, `out_data` is unchanged, and no `pop` toggle occurs.
- 254 random pushes with `CNT_W`=8, full drain: output is non-decreasing and `count`=254. Repeat with 300 elements at `CNT_W`=8: `count` saturates at 255.
- Pulse `rstn` low mid-drain after element 3: all outputs 0 and `cst`=`ST_IDLE`. A restart drains the remaining elements correctly.
- With `SORT_DRAIN_CHECK_EN`, drive `tx_data` from a bench model as 4, 2: `order_err`=1 after the second acceptance, then cleared by the next `start` toggle.
